// File: rtl/ysyx_23060025_wbu_commit.sv
// rtl/ysyx_23060025_wbu_commit.sv - write-back/commit stage owning GPR write-out and the machine CSR file
module ysyx_23060025_wbu_commit #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic                lsu_valid_i,
  output logic                wbu_ready_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [2:0]          csr_type_i,
  input  logic [11:0]         csr_waddr_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  input  logic                ebreak_flag_i,
  output logic                rf_wen_o,
  output logic [4:0]          rf_waddr_o,
  output logic [DATA_LEN-1:0] rf_wdata_o,
  input  logic [11:0]         csr_raddr_i,
  output logic [DATA_LEN-1:0] csr_rdata_o,
  output logic                wbu_valid_o,
  input  logic                ifu_ready_i,
  output logic                redirect_o,
  output logic [ADDR_LEN-1:0] redirect_pc_o,
  output logic                halt_o
);

  typedef enum logic [1:0] {IDLE, COMMIT, WAIT_IFU, HALT} state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MINSTL  = 12'hB02;
  localparam logic [11:0] CSR_MINSTH  = 12'hB82;

  state_t state, state_next;

  logic                pl_wd;
  logic [4:0]          pl_wreg;
  logic [DATA_LEN-1:0] pl_wdata;
  logic [2:0]          pl_csr_type;
  logic [11:0]         pl_csr_waddr;
  logic [DATA_LEN-1:0] pl_csr_wdata;
  logic                pl_ebreak;

  logic [DATA_LEN-1:0] mstatus;
  logic [ADDR_LEN-1:0] mtvec;
  logic [ADDR_LEN-1:0] mepc;
  logic [DATA_LEN-1:0] mcause;
  logic [63:0]         minstret;

  logic accept, is_csrw, is_ecall, is_mret;

  assign accept   = lsu_valid_i & wbu_ready_o;
  assign is_csrw  = (pl_csr_type == 3'd1);
  assign is_ecall = (pl_csr_type == 3'd2);
  assign is_mret  = (pl_csr_type == 3'd3);

  assign wbu_ready_o = rstn & (state == IDLE);
  // Gated by rstn so a commit interrupted by reset never reaches the register file.
  assign rf_wen_o    = rstn & (state == COMMIT) & pl_wd & (pl_wreg != 5'd0);
  assign rf_waddr_o  = pl_wreg;
  assign rf_wdata_o  = pl_wdata;
  assign wbu_valid_o = (state == COMMIT) | (state == WAIT_IFU);
  assign redirect_o  = wbu_valid_o & (is_ecall | is_mret);
  assign halt_o      = (state == HALT);
  // ecall never writes mtvec and mret never writes mepc, so the target stays stable in WAIT_IFU.
  assign redirect_pc_o = !redirect_o ? '0 :
                         is_ecall    ? {mtvec[ADDR_LEN-1:2], 2'b00} : mepc;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = COMMIT;
      COMMIT:   if (pl_ebreak) state_next = HALT;
                else if (ifu_ready_i) state_next = IDLE;
                else state_next = WAIT_IFU;
      WAIT_IFU: if (ifu_ready_i) state_next = IDLE;
      HALT:     state_next = HALT;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      CSR_MSTATUS: csr_rdata_o = mstatus;
      CSR_MTVEC:   csr_rdata_o = mtvec;
      CSR_MEPC:    csr_rdata_o = mepc;
      CSR_MCAUSE:  csr_rdata_o = mcause;
      CSR_MINSTL:  csr_rdata_o = minstret[31:0];
      CSR_MINSTH:  csr_rdata_o = minstret[63:32];
      default:     csr_rdata_o = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state        <= IDLE;
      pl_wd        <= 1'b0;
      pl_wreg      <= '0;
      pl_wdata     <= '0;
      pl_csr_type  <= '0;
      pl_csr_waddr <= '0;
      pl_csr_wdata <= '0;
      pl_ebreak    <= 1'b0;
      mstatus      <= 32'h0000_1800;
      mtvec        <= '0;
      mepc         <= '0;
      mcause       <= '0;
      minstret     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        pl_wd        <= wd_i;
        pl_wreg      <= wreg_i;
        pl_wdata     <= wdata_i;
        pl_csr_type  <= csr_type_i;
        pl_csr_waddr <= csr_waddr_i;
        pl_csr_wdata <= csr_wdata_i;
        pl_ebreak    <= ebreak_flag_i;
      end
      if (state == COMMIT) begin
        // Later assignments win, so a direct minstret write replaces the increment.
        minstret <= minstret + 64'd1;
        if (is_csrw) begin
          case (pl_csr_waddr)
            CSR_MSTATUS: mstatus  <= pl_csr_wdata;
            CSR_MTVEC:   mtvec    <= pl_csr_wdata;
            CSR_MEPC:    mepc     <= pl_csr_wdata;
            CSR_MCAUSE:  mcause   <= pl_csr_wdata;
            CSR_MINSTL:  minstret <= {minstret[63:32], pl_csr_wdata};
            CSR_MINSTH:  minstret <= {pl_csr_wdata, minstret[31:0]};
            default: ;
          endcase
        end else if (is_ecall) begin
          mepc          <= pl_csr_wdata;
          mcause        <= 32'd11;
          mstatus[7]    <= mstatus[3];
          mstatus[3]    <= 1'b0;
          mstatus[12:11] <= 2'b11;
        end else if (is_mret) begin
          mstatus[3] <= mstatus[7];
          mstatus[7] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_wbu_commit.sv
// tb/tb_ysyx_23060025_wbu_commit.sv - directed self-checking bench for the commit stage
module tb_ysyx_23060025_wbu_commit;
  logic        clock;
  logic        rstn;
  logic        lsu_valid_i;
  logic        wbu_ready_o;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] wdata_i;
  logic [2:0]  csr_type_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        ebreak_flag_i;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        wbu_valid_o;
  logic        ifu_ready_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        halt_o;

  int checks = 0;
  int errors = 0;
  int wen_count = 0;

  ysyx_23060025_wbu_commit dut (
    .clock(clock), .rstn(rstn), .lsu_valid_i(lsu_valid_i), .wbu_ready_o(wbu_ready_o),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .csr_type_i(csr_type_i),
    .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i), .ebreak_flag_i(ebreak_flag_i),
    .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o), .wbu_valid_o(wbu_valid_o),
    .ifu_ready_i(ifu_ready_i), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .halt_o(halt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (rf_wen_o) wen_count++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic rd(input logic [11:0] addr);
    csr_raddr_i = addr;
    #1;
  endtask

  // Presents one payload, lets it be accepted, and returns inside the commit cycle.
  task automatic commit_op(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata,
                           input logic [2:0] ctype, input logic [11:0] caddr,
                           input logic [31:0] cdata, input logic ebreak);
    wd_i = wd; wreg_i = wreg; wdata_i = wdata; csr_type_i = ctype;
    csr_waddr_i = caddr; csr_wdata_i = cdata; ebreak_flag_i = ebreak;
    lsu_valid_i = 1'b1;
    @(negedge clock);
    lsu_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    rstn = 1'b0; lsu_valid_i = 1'b0; wd_i = 1'b0; wreg_i = '0; wdata_i = '0;
    csr_type_i = '0; csr_waddr_i = '0; csr_wdata_i = '0; ebreak_flag_i = 1'b0;
    csr_raddr_i = 12'h300; ifu_ready_i = 1'b1;
    step(); step();
    chk("ready_in_reset", wbu_ready_o, 0);
    rstn = 1'b1; #1;
    chk("reset_ready", wbu_ready_o, 1);
    chk("reset_valid", wbu_valid_o, 0);
    chk("reset_wen", rf_wen_o, 0);
    chk("reset_wdata", rf_wdata_o, 0);
    chk("reset_halt", halt_o, 0);
    chk("reset_mstatus", csr_rdata_o, 32'h0000_1800);

    commit_op(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("t1_wen", rf_wen_o, 1);
    chk("t1_waddr", rf_waddr_o, 5);
    chk("t1_wdata", rf_wdata_o, 32'hDEAD_BEEF);
    chk("t1_valid", wbu_valid_o, 1);
    chk("t1_ready_busy", wbu_ready_o, 0);
    step();
    chk("t1_wen_off", rf_wen_o, 0);
    chk("t1_idle", wbu_ready_o, 1);
    rd(12'hB02); chk("t1_minstret", csr_rdata_o, 1);

    commit_op(1, 0, 32'h1111_2222, 0, 0, 0, 0);
    chk("t2_wen_x0", rf_wen_o, 0);
    chk("t2_valid", wbu_valid_o, 1);
    step();
    rd(12'hB02); chk("t2_minstret", csr_rdata_o, 2);

    commit_op(0, 0, 0, 1, 12'h300, 32'h0000_0008, 0);
    step();
    commit_op(0, 0, 0, 1, 12'h305, 32'h8000_0803, 0);
    step();
    rd(12'h305); chk("t3_mtvec", csr_rdata_o, 32'h8000_0803);
    commit_op(0, 0, 0, 2, 0, 32'h8000_0100, 0);
    chk("t3_ecall_redirect", redirect_o, 1);
    chk("t3_ecall_pc", redirect_pc_o, 32'h8000_0800);
    rd(12'h341); chk("t3_no_bypass", csr_rdata_o, 0);
    step();
    chk("t3_redirect_off", redirect_o, 0);
    rd(12'h341); chk("t3_mepc", csr_rdata_o, 32'h8000_0100);
    rd(12'h342); chk("t3_mcause", csr_rdata_o, 11);
    rd(12'h300); chk("t3_mstatus_trap", csr_rdata_o, 32'h0000_1880);
    commit_op(0, 0, 0, 3, 0, 0, 0);
    chk("t3_mret_redirect", redirect_o, 1);
    chk("t3_mret_pc", redirect_pc_o, 32'h8000_0100);
    step();
    rd(12'h300); chk("t3_mstatus_mret", csr_rdata_o, 32'h0000_1888);
    rd(12'hB02); chk("t3_minstret", csr_rdata_o, 6);

    ifu_ready_i = 1'b0;
    commit_op(1, 7, 32'h1234_5678, 0, 0, 0, 0);
    chk("t4_wen", rf_wen_o, 1);
    chk("t4_valid0", wbu_valid_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_valid_hold", wbu_valid_o, 1);
      chk("t4_ready_low", wbu_ready_o, 0);
      chk("t4_wen_low", rf_wen_o, 0);
    end
    ifu_ready_i = 1'b1;
    step();
    chk("t4_valid_drop", wbu_valid_o, 0);
    chk("t4_ready_back", wbu_ready_o, 1);
    chk("t4_wen_count", wen_count, 2);

    commit_op(0, 0, 0, 1, 12'hB82, 32'hFFFF_FFFF, 0); step();
    commit_op(0, 0, 0, 1, 12'hB02, 32'hFFFF_FFFF, 0); step();
    rd(12'hB82); chk("t5_preset_hi", csr_rdata_o, 32'hFFFF_FFFF);
    commit_op(0, 0, 0, 0, 0, 0, 0); step();
    rd(12'hB02); chk("t5_wrap_lo", csr_rdata_o, 0);
    rd(12'hB82); chk("t5_wrap_hi", csr_rdata_o, 0);
    commit_op(0, 0, 0, 1, 12'hB82, 32'hFFFF_FFFF, 0); step();
    commit_op(0, 0, 0, 1, 12'hB02, 32'hFFFF_FFFF, 0); step();
    commit_op(0, 0, 0, 1, 12'hB02, 32'h0000_0007, 0); step();
    rd(12'hB02); chk("t5_override_lo", csr_rdata_o, 7);
    rd(12'hB82); chk("t5_override_hi", csr_rdata_o, 32'hFFFF_FFFF);
    commit_op(0, 0, 0, 1, 12'h123, 32'h0000_0005, 0); step();
    rd(12'h123); chk("unmapped_read", csr_rdata_o, 0);
    commit_op(0, 0, 0, 5, 0, 32'h8000_0000, 0);
    chk("type5_no_redirect", redirect_o, 0);
    step();
    rd(12'hB02); chk("type5_minstret", csr_rdata_o, 9);

    commit_op(0, 0, 0, 0, 0, 0, 1);
    chk("t6_ebreak_valid", wbu_valid_o, 1);
    step();
    chk("t6_halt", halt_o, 1);
    chk("t6_ready", wbu_ready_o, 0);
    chk("t6_valid", wbu_valid_o, 0);
    wd_i = 1'b1; wreg_i = 5'd9; lsu_valid_i = 1'b1;
    step(); step();
    chk("t6_halt_sticky", halt_o, 1);
    chk("t6_no_wen", rf_wen_o, 0);
    lsu_valid_i = 1'b0;
    rd(12'hB02); chk("t6_minstret", csr_rdata_o, 32'h0000_000A);
    rstn = 1'b0;
    step();
    rstn = 1'b1; #1;
    chk("t6_reset_halt", halt_o, 0);
    chk("t6_reset_ready", wbu_ready_o, 1);
    rd(12'h300); chk("t6_reset_mstatus", csr_rdata_o, 32'h0000_1800);
    rd(12'hB82); chk("t6_reset_minstret_hi", csr_rdata_o, 0);

    commit_op(1, 3, 32'hCAFE_F00D, 0, 0, 0, 0);
    rstn = 1'b0; #1;
    chk("midreset_wen", rf_wen_o, 0);
    step();
    rstn = 1'b1; #1;
    chk("midreset_valid", wbu_valid_o, 0);
    chk("midreset_ready", wbu_ready_o, 1);
    rd(12'hB02); chk("midreset_minstret", csr_rdata_o, 0);
    chk("final_wen_count", wen_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
